// File: rtl/pen_pkg.sv
// Shared constants for the pen pixel writer: screen geometry, the no-blob marker,
// camera-to-screen scale factor and FSM state encodings.
package pen_pkg;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;

  localparam logic [9:0] NO_BLOB = 10'h3FF;

  // Camera 1024x768 maps onto 640x480 as *5/8 on both axes.
  localparam logic [12:0] SCALE_MUL = 13'd5;
  localparam int          SCALE_SHR = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCALE = 2'd1;
  localparam logic [1:0] ST_ADDR  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  function automatic logic [9:0] scale_clamp(input logic [9:0] v, input logic [9:0] lim);
    logic [12:0] p;
    logic [9:0]  s;
    p = 13'(v) * SCALE_MUL;
    s = 10'(p >> SCALE_SHR);
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/pen_avg4.sv
// 4-sample moving average on both axes; flush empties the window, shift pushes a sample.
// Outputs are registered-state derived (no input-to-output path); fill saturates at 4.
module pen_avg4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       shift_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic [9:0] avg_x_o,
  output logic [9:0] avg_y_o,
  output logic [2:0] fill_o,
  output logic       full_o
);

  logic [3:0][9:0] xs_q, xs_d;
  logic [3:0][9:0] ys_q, ys_d;
  logic [2:0]      fill_q, fill_d;
  logic [11:0]     sum_x, sum_y;

  always_comb begin
    xs_d   = xs_q;
    ys_d   = ys_q;
    fill_d = fill_q;
    if (flush_i) begin
      fill_d = 3'd0;
    end else if (shift_i) begin
      xs_d = {xs_q[2:0], x_i};
      ys_d = {ys_q[2:0], y_i};
      if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xs_q   <= '0;
      ys_q   <= '0;
      fill_q <= 3'd0;
    end else begin
      xs_q   <= xs_d;
      ys_q   <= ys_d;
      fill_q <= fill_d;
    end
  end

  assign sum_x = 12'(xs_q[0]) + 12'(xs_q[1]) + 12'(xs_q[2]) + 12'(xs_q[3]);
  assign sum_y = 12'(ys_q[0]) + 12'(ys_q[1]) + 12'(ys_q[2]) + 12'(ys_q[3]);

  assign avg_x_o = 10'(sum_x >> 2);
  assign avg_y_o = 10'(sum_y >> 2);
  assign fill_o  = fill_q;
  assign full_o  = (fill_q == 3'd4);

endmodule

// File: rtl/pen_pixel_writer.sv
// Turns filtered pen samples into single-pixel framebuffer writes; wr_req rises 3 cycles after
// the accepting strobe and is held until wr_ack, with samples arriving while busy counted as drops.
module pen_pixel_writer #(
  parameter int                  SCR_W      = pen_pkg::SCR_W,
  parameter int                  SCR_H      = pen_pkg::SCR_H,
  parameter int                  ADDR_W     = 19,
  parameter int                  COLOUR_W   = 4,
  parameter logic [COLOUR_W-1:0] PEN_COLOUR = 4'hF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cam_valid,
  input  logic [9:0]          cam_x,
  input  logic [9:0]          cam_y,
  input  logic                enable,
  output logic                wr_req,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [COLOUR_W-1:0] wr_data,
  input  logic                wr_ack,
  output logic                pen_down,
  output logic [7:0]          drop_count
);

  import pen_pkg::*;

  logic [1:0]        state_q, state_d;
  logic [9:0]        sx_q, sx_d, sy_q, sy_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              last_vld_q, last_vld_d;
  logic              wr_req_q, wr_req_d;
  logic [7:0]        drop_q, drop_d;

  logic              idle, no_blob, accept, flush, shift;
  logic [9:0]        avg_x, avg_y;
  logic [2:0]        fill;
  logic              full;
  logic [ADDR_W-1:0] addr_c;

  assign idle    = (state_q == ST_IDLE);
  assign no_blob = (cam_x == NO_BLOB) || (cam_y == NO_BLOB);
  assign accept  = cam_valid && enable && idle;
  // Disabling drawing acts like a no-blob sample every cycle.
  assign flush   = !enable || (accept && no_blob);
  assign shift   = accept && !no_blob;

  pen_avg4 u_avg (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .shift_i (shift),
    .x_i     (cam_x),
    .y_i     (cam_y),
    .avg_x_o (avg_x),
    .avg_y_o (avg_y),
    .fill_o  (fill),
    .full_o  (full)
  );

  // y*640 + x as (y<<9) + (y<<7) + x
  assign addr_c = (ADDR_W'(sy_q) << 9) + (ADDR_W'(sy_q) << 7) + ADDR_W'(sx_q);

  always_comb begin
    state_d     = state_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    wr_addr_d   = wr_addr_q;
    wr_req_d    = wr_req_q;
    last_addr_d = last_addr_q;
    last_vld_d  = last_vld_q;
    drop_d      = drop_q;

    if (cam_valid && enable && !idle && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    if (flush) last_vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The shift this cycle completes the window when fill is already 3 or 4.
        if (shift && fill >= 3'd3) state_d = ST_SCALE;
      end
      ST_SCALE: begin
        sx_d    = scale_clamp(avg_x, 10'(SCR_W - 1));
        sy_d    = scale_clamp(avg_y, 10'(SCR_H - 1));
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (last_vld_q && addr_c == last_addr_q) begin
          state_d = ST_IDLE;
        end else begin
          wr_addr_d = addr_c;
          wr_req_d  = 1'b1;
          state_d   = ST_WRITE;
        end
      end
      default: begin
        if (wr_ack) begin
          wr_req_d    = 1'b0;
          last_addr_d = wr_addr_q;
          last_vld_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sx_q        <= '0;
      sy_q        <= '0;
      wr_addr_q   <= '0;
      wr_req_q    <= 1'b0;
      last_addr_q <= '0;
      last_vld_q  <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      wr_addr_q   <= wr_addr_d;
      wr_req_q    <= wr_req_d;
      last_addr_q <= last_addr_d;
      last_vld_q  <= last_vld_d;
      drop_q      <= drop_d;
    end
  end

  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = PEN_COLOUR;
  assign pen_down   = full;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pen_pixel_writer.sv
// Bench for pen_pixel_writer: directed scenarios plus randomized traffic against a
// transaction-level reference model (sample window, arithmetic scaling, timing offsets).
module tb_pen_pixel_writer;

  logic        clk = 1'b0;
  logic        reset, cam_valid, enable, wr_ack;
  logic [9:0]  cam_x, cam_y;
  logic        wr_req, pen_down;
  logic [18:0] wr_addr;
  logic [3:0]  wr_data;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int wx[$];
  int wy[$];
  int m_last, m_addr, m_drop, m_acc, k;
  bit m_last_vld, m_active, m_write;

  pen_pixel_writer dut (
    .clk        (clk),
    .reset      (reset),
    .cam_valid  (cam_valid),
    .cam_x      (cam_x),
    .cam_y      (cam_y),
    .enable     (enable),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .pen_down   (pen_down),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  function automatic int scale_ref(input int a, input int lim);
    int s;
    s = (a * 5) / 8;
    return (s > lim) ? lim : s;
  endfunction

  // One clock: drive inputs, advance the model at the edge, then settle for sampling.
  task automatic step(input logic cv, input logic [9:0] x, input logic [9:0] y,
                      input logic en, input logic ack, input logic rst);
    bit busy, done;
    int sx_sum, sy_sum;
    cam_valid = cv; cam_x = x; cam_y = y; enable = en; wr_ack = ack; reset = rst;
    @(posedge clk);
    done = 0;
    if (rst) begin
      wx.delete(); wy.delete();
      m_last_vld = 0; m_last = 0; m_drop = 0; m_active = 0; m_write = 0;
    end else begin
      busy = m_active;
      if (m_active) begin
        if (k == m_acc + 2) begin
          m_write = !(m_last_vld && m_addr == m_last);
          if (!m_write) m_active = 0;
        end else if (k > m_acc + 2 && ack) begin
          m_active = 0; m_write = 0; done = 1;
        end
      end
      if (cv && en && busy && m_drop < 255) m_drop++;
      if (!en) begin
        wx.delete(); wy.delete(); m_last_vld = 0;
      end else if (cv && !busy) begin
        if (x == 10'd1023 || y == 10'd1023) begin
          wx.delete(); wy.delete(); m_last_vld = 0;
        end else begin
          wx.push_back(int'(x)); wy.push_back(int'(y));
          if (wx.size() > 4) begin void'(wx.pop_front()); void'(wy.pop_front()); end
          if (wx.size() == 4) begin
            sx_sum = 0; sy_sum = 0;
            foreach (wx[i]) begin sx_sum += wx[i]; sy_sum += wy[i]; end
            m_addr = scale_ref(sy_sum / 4, 479) * 640 + scale_ref(sx_sum / 4, 639);
            m_active = 1; m_write = 0; m_acc = k;
          end
        end
      end
      if (done) begin m_last = m_addr; m_last_vld = 1; end
    end
    k++;
    #1;
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 10'd0, 10'd0, 1'b1, ack, 1'b0);
  endtask

  task automatic test_reset;
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req: got %0b want 0", wr_req); end
    checks++; if (wr_addr !== 19'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 4'hF) begin errors++; $display("FAIL reset_wr_data: got %0h want f", wr_data); end
    checks++; if (pen_down !== 1'b0) begin errors++; $display("FAIL reset_pen_down: got %0b want 0", pen_down); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_first_write;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 10'd512, 10'd384, 1'b1, 1'b1, 1'b0);
      checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL first_early_req%0d: got %0b want 0", i, wr_req); end
    end
    idle(1'b1);
    checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL first_lat_early: got %0b want 0", wr_req); end
    idle(1'b1);
    checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL first_req: got %0b want 1", wr_req); end
    checks++; if (wr_addr !== 19'd153920) begin errors++; $display("FAIL first_addr: got %0d want 153920", wr_addr); end
    checks++; if (wr_data !== 4'hF) begin errors++; $display("FAIL first_data: got %0h want f", wr_data); end
    checks++; if (pen_down !== 1'b1) begin errors++; $display("FAIL first_pen_down: got %0b want 1", pen_down); end
    idle(1'b1);
    checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL first_req_drop: got %0b want 0", wr_req); end
    idle(1'b1);
  endtask

  task automatic test_same_addr;
    step(1'b1, 10'd512, 10'd384, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL same_addr_req%0d: got %0b want 0", i, wr_req); end
    end
    step(1'b1, 10'd520, 10'd384, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL shift_req: got %0b want 1", wr_req); end
    checks++; if (wr_addr !== 19'd153921) begin errors++; $display("FAIL shift_addr: got %0d want 153921", wr_addr); end
    idle(1'b1);
    idle(1'b1);
  endtask

  task automatic test_no_blob;
    step(1'b1, 10'd1023, 10'd1023, 1'b1, 1'b1, 1'b0);
    checks++; if (pen_down !== 1'b0) begin errors++; $display("FAIL noblob_pen_down: got %0b want 0", pen_down); end
    for (int s = 0; s < 3; s++) begin
      step(1'b1, 10'd100, 10'd100, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        idle(1'b1);
        checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL refill_req%0d_%0d: got %0b want 0", s, i, wr_req); end
      end
    end
    checks++; if (pen_down !== 1'b0) begin errors++; $display("FAIL refill_pen_down: got %0b want 0", pen_down); end
    step(1'b1, 10'd100, 10'd100, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL refill_req: got %0b want 1", wr_req); end
    checks++; if (wr_addr !== 19'd39742) begin errors++; $display("FAIL refill_addr: got %0d want 39742", wr_addr); end
    checks++; if (pen_down !== 1'b1) begin errors++; $display("FAIL refill_pen_up: got %0b want 1", pen_down); end
    idle(1'b1);
    idle(1'b1);
  endtask

  task automatic test_stall;
    step(1'b1, 10'd200, 10'd100, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      step((c % 4) == 0, 10'd300, 10'd300, 1'b1, 1'b0, 1'b0);
      if (c >= 2) begin
        checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL stall_req_c%0d: got %0b want 1", c, wr_req); end
        checks++; if (wr_addr !== 19'd39758) begin errors++; $display("FAIL stall_addr_c%0d: got %0d want 39758", c, wr_addr); end
      end
    end
    checks++; if (drop_count !== 8'd5) begin errors++; $display("FAIL stall_drops: got %0d want 5", drop_count); end
    idle(1'b1);
    checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL stall_release: got %0b want 0", wr_req); end
    idle(1'b1);
  endtask

  task automatic test_reset_in_write;
    step(1'b1, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    checks++; if (wr_req !== 1'b1 || wr_addr !== 19'd39789) begin errors++; $display("FAIL rstw_pre: got req=%0b addr=%0d want req=1 addr=39789", wr_req, wr_addr); end
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b1);
    checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL rstw_req: got %0b want 0", wr_req); end
    checks++; if (pen_down !== 1'b0) begin errors++; $display("FAIL rstw_pen_down: got %0b want 0", pen_down); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rstw_drop: got %0d want 0", drop_count); end
    step(1'b1, 10'd400, 10'd400, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL rstw_single_req%0d: got %0b want 0", i, wr_req); end
    end
  endtask

  task automatic test_corners;
    step(1'b1, 10'd1023, 10'd500, 1'b1, 1'b1, 1'b0);
    checks++; if (pen_down !== 1'b0) begin errors++; $display("FAIL corner_flush: got %0b want 0", pen_down); end
    for (int i = 0; i < 4; i++) step(1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    checks++; if (wr_req !== 1'b1 || wr_addr !== 19'd0) begin errors++; $display("FAIL corner_origin: got req=%0b addr=%0d want req=1 addr=0", wr_req, wr_addr); end
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 10'd1022, 10'd767, 1'b1, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL corner_req%0d: got %0b want 1", i, wr_req); end
      if (i == 3) begin
        checks++; if (wr_addr !== 19'd307198) begin errors++; $display("FAIL corner_far_addr: got %0d want 307198", wr_addr); end
      end
      idle(1'b1);
      idle(1'b1);
    end
  endtask

  task automatic test_drop_saturate;
    step(1'b1, 10'd1000, 10'd700, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 270; i++) step(1'b1, 10'd10, 10'd10, 1'b1, 1'b0, 1'b0);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d want 255", drop_count); end
    checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL drop_sat_req_held: got %0b want 1", wr_req); end
    idle(1'b1);
    checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL drop_sat_release: got %0b want 0", wr_req); end
  endtask

  task automatic test_random;
    logic       cv, en, ack;
    logic [9:0] x, y;
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 1500; n++) begin
      cv  = ($urandom_range(0, 2) == 0);
      x   = ($urandom_range(0, 11) == 0) ? 10'd1023 : 10'(500 + $urandom_range(0, 12));
      y   = ($urandom_range(0, 15) == 0) ? 10'd1023 : 10'(300 + $urandom_range(0, 12));
      en  = ($urandom_range(0, 24) != 0);
      ack = ($urandom_range(0, 3) != 0);
      step(cv, x, y, en, ack, 1'b0);
      checks++; if (wr_req !== (m_active && m_write)) begin errors++; $display("FAIL rand_req@%0d: got %0b want %0b", n, wr_req, (m_active && m_write)); end
      if (m_active && m_write) begin
        checks++; if (wr_addr !== 19'(m_addr)) begin errors++; $display("FAIL rand_addr@%0d: got %0d want %0d", n, wr_addr, m_addr); end
      end
      checks++; if (pen_down !== (wx.size() == 4)) begin errors++; $display("FAIL rand_pen_down@%0d: got %0b want %0b", n, pen_down, (wx.size() == 4)); end
      checks++; if (drop_count !== 8'(m_drop)) begin errors++; $display("FAIL rand_drop@%0d: got %0d want %0d", n, drop_count, m_drop); end
    end
  endtask

  initial begin
    k = 0; m_acc = 0; m_addr = 0; m_last = 0; m_drop = 0;
    m_last_vld = 0; m_active = 0; m_write = 0;
    test_reset();
    test_first_write();
    test_same_addr();
    test_no_blob();
    test_stall();
    test_reset_in_write();
    test_corners();
    test_drop_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pen_pixel_writer.md
Name: pen_pixel_writer

Overview:
- Consumes pen position samples from the IR camera stage (10-bit x/y in 1024x768 camera space) and produces single-pixel write requests into the VGA framebuffer write port.
- Rejects "no blob" samples and smooths positions with a 4-sample moving average.
- Scales camera space to 640x480 screen space and forms a linear framebuffer address.
- Sits between the camera I2C reader and the framebuffer RAM arbiter.

Parameters:
- SCR_W, 640, screen width in pixels; address stride.
- SCR_H, 480, screen height in pixels; y clamp bound.
- ADDR_W, 19, framebuffer address width.
- COLOUR_W, 4, pixel data width.
- PEN_COLOUR, 4'hF, data written for every pen pixel.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cam_valid  in  1  one-cycle strobe; cam_x/cam_y hold a fresh sample.
- cam_x  in  10  camera x, 0..1023.
- cam_y  in  10  camera y, 0..767; 1023 means no blob.
- enable  in  1  drawing enabled; when 0, samples are discarded and the filter is flushed.
- wr_req  out  1  write request to framebuffer.
- wr_addr  out  ADDR_W  y*SCR_W + x.
- wr_data  out  COLOUR_W  always PEN_COLOUR.
- wr_ack  in  1  framebuffer accepted the write this cycle.
- pen_down  out  1  filter full and blob present.
- drop_count  out  8  saturating count of valid samples lost while busy.

Behaviour:
Reset
- wr_req=0, wr_addr=0, wr_data=PEN_COLOUR, pen_down=0, drop_count=0.
- Filter fill count=0, last-written valid flag=0, state=IDLE.
- Any write in progress is abandoned without waiting for wr_ack.

Sample acceptance
- A sample is taken only on a cycle with cam_valid=1, enable=1 and state=IDLE.
- Sample with cam_y==1023 or cam_x==1023 (no blob): flush the filter (fill=0), pen_down<=0, last-written flag cleared. No write.
- cam_valid while state!=IDLE: the sample is dropped and drop_count increments, saturating at 255.
- enable=0: behaves as a no-blob sample on every cycle. drop_count is not incremented.

Filter
- 4-entry shift register per axis; sums are 12 bits.
- Fill counter 0..4 saturates at 4.
- Average = sum>>2, computed only when fill==4. The first three samples after a flush produce no write.
- pen_down=1 once fill reaches 4, until the next flush.

State machine: IDLE -> SCALE -> ADDR -> WRITE -> IDLE
- IDLE: on an accepted blob sample, shift it in and increment fill. Go to SCALE if the new fill==4, else stay in IDLE.
- SCALE (1 cycle): sx=(avg_x*5)>>3, sy=(avg_y*5)>>3, with 13-bit intermediates. Clamp sx to SCR_W-1 and sy to SCR_H-1.
- ADDR (1 cycle): addr=sy*SCR_W+sx, using shift-add (sy<<9)+(sy<<7)+sx.
  - If the last-written flag is set and addr equals the last-written address: go to IDLE, no write.
  - Otherwise register wr_addr and set wr_req=1, then go to WRITE.
- WRITE: hold wr_req, wr_addr and wr_data stable until the first cycle with wr_ack=1.
  - That cycle: wr_req<=0, store addr as last-written, set the flag, go to IDLE.
  - Unbounded wait is legal.
  - wr_ack while not in WRITE is ignored.

Latency and boundaries
- Latency: wr_req is visible 3 cycles after the accepting cam_valid edge (IDLE->SCALE->ADDR->WRITE).
- Back-to-back: IDLE accepts a new sample on the cycle after wr_ack.
- Boundaries: avg 1023 is impossible (filtered out), avg_x=1022 -> sx=638; avg_y=767 -> sy=479. Clamping is a safety net only.

Decomposition:
- Shared package pen_pkg holds:
  - SCR_W/SCR_H.
  - NO_BLOB=10'h3FF.
  - Scale constants (5, 3).
  - State encodings IDLE/SCALE/ADDR/WRITE.
- One sub-module, pen_avg4: the shift register, fill counter and sums for both axes, with flush and shift inputs and avg_x/avg_y/full outputs.
- The FSM, scaling and address logic stay in the top module.

Test Plan:
- Reset, then four cam_valid samples (512,384), wr_ack tied high -> exactly one wr_req, 3 cycles after the 4th strobe; sx=320, sy=240, wr_addr=153920, wr_data=4'hF; pen_down=1.
- Fifth identical sample -> no wr_req (same address suppressed). Sixth sample (520,384) -> average x=514 gives sx=321, wr_addr=153921.
- No-blob sample (x=1023, y=1023) after a full filter -> pen_down falls next cycle. The next three blob samples produce no write; the fourth does.
- wr_ack held low 20 cycles while 5 cam_valid strobes arrive -> wr_req and wr_addr stable throughout; drop_count=5; one write completes when wr_ack rises.
- reset asserted while in WRITE with wr_ack low -> next cycle wr_req=0, pen_down=0, drop_count=0; a subsequent single sample produces no write.
- Samples (0,0)x4 then (1022,767)x4 -> wr_addr=0, then after the filter settles, final wr_addr=479*640+638=307198.
